// File: rtl/bp_pkg.sv
// Shared types and the saturating-counter step for the branch history table.
// Imported by the update queue and the table controller.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

    localparam bp_ctr_t BP_INIT_CTR = WNT;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) begin
                result = bp_ctr_t'(ctr + 2'd1);
            end
        end else begin
            if (ctr != SNT) begin
                result = bp_ctr_t'(ctr - 2'd1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small FIFO holding resolved-branch updates between execute and the table.
// A pop reads the current head, so an entry pushed this cycle is never popped this cycle.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : AW'(wr_ptr_q + 1'b1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : AW'(rd_ptr_q + 1'b1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // Flush discards whatever is pending, including a same-cycle push.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_history_ctrl.sv
// Table of 2-bit saturating counters giving taken/not-taken predictions to fetch,
// trained by a queue of resolved outcomes and initialized by a one-entry-per-cycle sweep.
module branch_history_ctrl
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int INDEX_W   = $clog2(ENTRIES),
    parameter int UPD_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic            lookup_is_branch,
    output logic            pred_taken,
    output logic            init_busy,
    input  logic            bht_clear,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            upd_ready
);

    localparam int UPD_W = INDEX_W + 1;

    bp_state_t          state_q, state_d;
    logic [INDEX_W-1:0] init_idx_q, init_idx_d;
    bp_ctr_t            table_q [ENTRIES];
    bp_ctr_t            table_d [ENTRIES];

    logic [INDEX_W-1:0] lookup_idx;
    logic [UPD_W-1:0]   push_entry;
    logic [UPD_W-1:0]   head_entry;
    logic [INDEX_W-1:0] head_idx;
    logic               head_taken;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               unused_pc_bits;

    assign lookup_idx     = lookup_pc[INDEX_W+1:2];
    assign push_entry     = {upd_pc[INDEX_W+1:2], upd_taken};
    assign head_idx       = head_entry[UPD_W-1:1];
    assign head_taken     = head_entry[0];
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:INDEX_W+2], lookup_pc[1:0],
                              upd_pc[XLEN-1:INDEX_W+2], upd_pc[1:0]};

    assign init_busy  = (state_q == INIT);
    assign upd_ready  = ~fifo_full & ~init_busy;
    assign fifo_push  = upd_valid & upd_ready;
    assign pred_taken = lookup_is_branch & ~init_busy & table_q[lookup_idx][1];

    bp_update_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (UPD_W)
    ) u_upd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (bht_clear),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        table_d    = table_q;
        fifo_pop   = 1'b0;
        case (state_q)
            INIT: begin
                table_d[init_idx_q] = BP_INIT_CTR;
                if (bht_clear) begin
                    init_idx_d = '0;
                end else if (init_idx_q == INDEX_W'(ENTRIES-1)) begin
                    state_d    = RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = INDEX_W'(init_idx_q + 1'b1);
                end
            end
            RUN: begin
                // A clear drops the pending queue instead of draining its head.
                if (bht_clear) begin
                    state_d    = INIT;
                    init_idx_d = '0;
                end else if (!fifo_empty) begin
                    fifo_pop          = 1'b1;
                    table_d[head_idx] = bp_ctr_next(table_q[head_idx], head_taken);
                end
            end
            default: begin
                state_d    = INIT;
                init_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

endmodule

// File: tb/tb_branch_history_ctrl.sv
// Scoreboard bench for branch_history_ctrl: a behavioural model predicts every cycle's
// outputs into a queue, a monitor pops and compares; directed scenarios then random traffic.
module tb_branch_history_ctrl;

    localparam int XLEN      = 32;
    localparam int ENTRIES   = 64;
    localparam int UPD_DEPTH = 2;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] lookup_pc;
    logic            lookup_is_branch;
    logic            pred_taken;
    logic            init_busy;
    logic            bht_clear;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_ready;

    branch_history_ctrl #(
        .XLEN      (XLEN),
        .ENTRIES   (ENTRIES),
        .UPD_DEPTH (UPD_DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .lookup_is_branch (lookup_is_branch),
        .pred_taken       (pred_taken),
        .init_busy        (init_busy),
        .bht_clear        (bht_clear),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_ready        (upd_ready)
    );

    typedef struct {
        bit pred;
        bit busy;
        bit ready;
    } exp_t;

    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];
    upd_t mQ[$];
    int   mTbl[ENTRIES];
    int   sweepLeft  = 0;
    bit   modelValid = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int idxOf(input logic [XLEN-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated just before each rising edge with the inputs that edge will see.
    always begin
        exp_t e;
        bit   acc;
        upd_t u;
        @(negedge clk);
        #3;
        if (modelValid) begin
            e.busy  = (sweepLeft > 0);
            e.ready = !e.busy && (mQ.size() < UPD_DEPTH);
            e.pred  = lookup_is_branch && !e.busy && (mTbl[idxOf(lookup_pc)] >= 2);
            expQ.push_back(e);
        end
        if (reset) begin
            sweepLeft  = ENTRIES;
            mQ.delete();
            modelValid = 1;
        end else if (modelValid) begin
            if (bht_clear) begin
                sweepLeft = ENTRIES;
                mQ.delete();
            end else if (sweepLeft > 0) begin
                mTbl[ENTRIES - sweepLeft] = 1;
                sweepLeft--;
            end else begin
                acc = upd_valid && (mQ.size() < UPD_DEPTH);
                if (mQ.size() > 0) begin
                    u = mQ.pop_front();
                    if (u.taken) mTbl[u.idx] = (mTbl[u.idx] >= 3) ? 3 : mTbl[u.idx] + 1;
                    else         mTbl[u.idx] = (mTbl[u.idx] <= 0) ? 0 : mTbl[u.idx] - 1;
                end
                if (acc) begin
                    u.idx   = idxOf(upd_pc);
                    u.taken = upd_taken;
                    mQ.push_back(u);
                end
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("init_busy", init_busy, e.busy);
            checkOutput("upd_ready", upd_ready, e.ready);
            checkOutput("pred_taken", pred_taken, e.pred);
        end
    end

    task automatic applyStimulus(input bit br, input logic [XLEN-1:0] lpc, input bit v,
                                 input logic [XLEN-1:0] upc, input bit tk,
                                 input bit clr, input bit rst);
        @(negedge clk);
        lookup_is_branch = br;
        lookup_pc        = lpc;
        upd_valid        = v;
        upd_pc           = upc;
        upd_taken        = tk;
        bht_clear        = clr;
        reset            = rst;
    endtask

    task automatic idle(input logic [XLEN-1:0] lpc);
        applyStimulus(1'b1, lpc, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Holds the update until the block is ready; returns once the accepting edge is next.
    task automatic sendUpdate(input logic [XLEN-1:0] pc, input bit tk, input logic [XLEN-1:0] lpc);
        int waited = 0;
        applyStimulus(1'b1, lpc, 1'b1, pc, tk, 1'b0, 1'b0);
        #1;
        while (!upd_ready && waited < 200) begin
            applyStimulus(1'b1, lpc, 1'b1, pc, tk, 1'b0, 1'b0);
            #1;
            waited++;
        end
        checkOutput("update accepted", upd_ready, 1'b1);
    endtask

    task automatic waitSweep(output int n);
        n = 0;
        idle('0);
        #2;
        while (init_busy && n < 300) begin
            n++;
            if (upd_ready) checkOutput("ready during sweep", upd_ready, 1'b0);
            idle('0);
            #2;
        end
    endtask

    task automatic lookupCheck(input string name, input logic [XLEN-1:0] lpc, input bit br, input bit exp);
        applyStimulus(br, lpc, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput(name, pred_taken, exp);
    endtask

    logic [XLEN-1:0] pool [8] = '{32'h0000_0040, 32'h0000_0100, 32'h0000_0200, 32'h0000_0044,
                                   32'h8000_0043, 32'h0000_01FC, 32'h1234_5678, 32'h0000_0380};

    initial begin
        int n;
        logic [XLEN-1:0] lpc;
        logic [XLEN-1:0] upc;

        reset = 1'b1; bht_clear = 1'b0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; lookup_pc = '0; lookup_is_branch = 1'b0;
        repeat (3) applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("reset init_busy", init_busy, 1'b1);
        checkOutput("reset upd_ready", upd_ready, 1'b0);
        checkOutput("reset pred_taken", pred_taken, 1'b0);

        waitSweep(n);
        checkCount("sweep length after reset", n, ENTRIES);
        lookupCheck("post-sweep pc 0x0", 32'h0, 1'b1, 1'b0);
        lookupCheck("post-sweep pc 0xFC", 32'hFC, 1'b1, 1'b0);

        // Saturation on one entry, then back down to weakly not-taken.
        repeat (3) sendUpdate(32'h40, 1'b1, 32'h40);
        idle(32'h40); idle(32'h40);
        lookupCheck("saturated taken 0x40", 32'h40, 1'b1, 1'b1);
        sendUpdate(32'h40, 1'b0, 32'h40);
        idle(32'h40); idle(32'h40);
        lookupCheck("one not-taken from ST", 32'h40, 1'b1, 1'b1);
        sendUpdate(32'h40, 1'b0, 32'h40);
        idle(32'h40); idle(32'h40);
        lookupCheck("two not-taken from ST", 32'h40, 1'b1, 1'b0);

        sendUpdate(32'h100, 1'b1, 32'h0);
        sendUpdate(32'h100, 1'b1, 32'h0);
        idle(32'h0); idle(32'h0);
        lookupCheck("alias 0x200", 32'h200, 1'b1, 1'b1);
        lookupCheck("neighbour 0x104", 32'h104, 1'b1, 1'b0);
        lookupCheck("not a branch", 32'h100, 1'b0, 1'b0);

        // Drain and lookup on the same index in the same cycle.
        sendUpdate(32'h380, 1'b1, 32'h380);
        lookupCheck("lookup during drain", 32'h380, 1'b1, 1'b0);
        lookupCheck("lookup after drain", 32'h380, 1'b1, 1'b1);

        sendUpdate(32'h48, 1'b1, 32'h48);
        applyStimulus(1'b1, 32'h48, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        waitSweep(n);
        checkCount("sweep length after clear", n, ENTRIES);
        lookupCheck("cleared update not applied", 32'h48, 1'b1, 1'b0);

        applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (30) idle('0);
        applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        waitSweep(n);
        checkCount("sweep length after mid-sweep reset", n, ENTRIES);

        // Back-pressure: four distinct updates held across the end of a sweep.
        applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        sendUpdate(32'h10, 1'b1, 32'h0);
        sendUpdate(32'h14, 1'b1, 32'h0);
        sendUpdate(32'h18, 1'b0, 32'h0);
        sendUpdate(32'h1C, 1'b1, 32'h0);
        idle('0); idle('0);
        lookupCheck("backpressure 0x10", 32'h10, 1'b1, 1'b1);
        lookupCheck("backpressure 0x14", 32'h14, 1'b1, 1'b1);
        lookupCheck("backpressure 0x18", 32'h18, 1'b1, 1'b0);
        lookupCheck("backpressure 0x1C", 32'h1C, 1'b1, 1'b1);

        for (int i = 0; i < 2500; i++) begin
            upc = ($urandom_range(0, 3) == 0) ? XLEN'($urandom()) : pool[$urandom_range(0, 7)];
            lpc = ($urandom_range(0, 3) == 0) ? XLEN'($urandom()) : pool[$urandom_range(0, 7)];
            applyStimulus($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 2) != 0, upc,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0,
                          $urandom_range(0, 599) == 0);
        end
        repeat (4) idle('0);
        checkCount("scoreboard drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
